idex_operand_stage: RTL and testbench
=====================================

# idex_operand_stage

ID/EX pipeline stage that latches decoded instructions and drives the ALU operand ports (A, B, ALUOP) one cycle later. It resolves operand forwarding from EX/MEM and MEM/WB, and detects load-use hazards so decode can stall. It inserts bubbles and honours downstream stall and flush. It sits directly between the decode stage and the ALU.

## Interface
- No parameters. Widths come from `cpu_types_pkg`: word_t is 32 bits, regbits_t is 5 bits, aluop_t is 4 bits.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- dec_valid  in  1  decode presents an instruction.
- dec_rs, dec_rt  in  5  source register numbers.
- dec_uses_rs, dec_uses_rt  in  1  instruction reads that source.
- dec_rdat1, dec_rdat2  in  32  register-file read data.
- dec_imm  in  32  immediate, already extended or shifted (LUI) by decode.
- dec_shamt  in  5  shift amount.
- dec_alusrc  in  1  B takes the immediate instead of the rt operand.
- dec_aluop  in  aluop_t  ALU operation.
- dec_wsel  in  5  destination register.
- dec_regwen  in  1  instruction writes a register.
- dec_memren  in  1  instruction is a load.
- exmem_wsel  in  5  EX/MEM destination register.
- exmem_regwen  in  1  EX/MEM writes a register.
- exmem_result  in  32  EX/MEM result.
- memwb_wsel  in  5  MEM/WB destination register.
- memwb_regwen  in  1  MEM/WB writes a register.
- memwb_result  in  32  MEM/WB result.
- hold  in  1  downstream stall; keep the current EX instruction.
- flush  in  1  squash the EX instruction (branch or jump resolve).
- load_use  out  1  combinational; decode must stall this cycle.
- ex_valid  out  1  EX slot holds a live instruction.
- A, B  out  32  ALU operand ports.
- ALUOP  out  aluop_t  ALU opcode port.
- ex_wsel  out  5  destination register, passed downstream.
- ex_regwen  out  1  register-write enable, passed downstream.
- ex_memren  out  1  load flag, passed downstream.
- ex_rtdata  out  32  forwarded rt operand (store data).

## Operation
- The latch holds: valid, rs, rt, uses_rs, uses_rt, opA, opB (raw rs and rt data), imm, shamt, alusrc, aluop, wsel, regwen, memren.
- **Forwarding (combinational).**
  - The resolved rs value comes from exmem_result if exmem_regwen, exmem_wsel==rs and rs!=0.
  - Otherwise it comes from memwb_result if memwb_regwen, memwb_wsel==rs and rs!=0.
  - Otherwise it is the latched opA.
  - rt is resolved the same way from opB.
  - EX/MEM always wins over MEM/WB.
  - Register 0 is never forwarded.
- **Operand select.**
  - If ALUOP is ALU_SLL or ALU_SRL: A = {27'b0, shamt} and B = resolved rt.
  - Otherwise: A = resolved rs, and B = imm if alusrc, else resolved rt.
  - ex_rtdata = resolved rt in all cases.
- **Load-use detection.** load_use = ex_valid & ex_memren & ex_wsel!=0 & ((dec_uses_rs & dec_rs==ex_wsel) | (dec_uses_rt & dec_rt==ex_wsel)). It is gated to 0 while hold or flush is high.
- **Update priority at each edge:**
  1. RST: clear everything.
  2. flush: valid <= 0; other fields don't-care.
  3. hold: keep all fields, but write the resolved rs/rt values back into opA/opB, so forwarded data survives MEM/WB retirement.
  4. load_use: insert a bubble (valid <= 0, regwen <= 0, memren <= 0).
  5. Else: capture all dec_* fields, with valid <= dec_valid.
- Any cycle with ex_valid=0 forces ex_regwen and ex_memren outputs to 0, regardless of latch contents.
- A flush during hold squashes the held instruction.

## Timing
- Latency: a decode input captured at edge N appears on A/B/ALUOP after edge N; the ALU result is available in the same cycle.
- Reset values:
  - ex_valid=0, ex_regwen=0, ex_memren=0, ex_wsel=0, ALUOP=0 (ALU_SLL encoding).
  - A=0, B=0, ex_rtdata=0; load_use=0.
- Forwarding paths are combinational within one cycle and have no added latency.
- load_use is asserted for exactly one cycle per load-use pair. The decode stage holds its inputs for that cycle, and the bubble clears the hazard on the next edge.
- RST asserted mid-hold or mid-hazard overrides all other controls on that edge.

## Structure
- `cpu_types_pkg` provides aluop_t, word_t and regbits_t, plus a new `idex_t` packed struct for the latched fields.
- A natural sub-module is `fwd_mux`, instantiated twice (once for rs, once for rt). It takes a source register number, the latched data and both forwarding ports, and returns the resolved word.
- The ALU connects through alu_if with modport alu. This block drives the tb-direction signals (A, B, ALUOP).

## Test plan
- **Reset:** RST=1 for two cycles with dec_valid=1 → ex_valid=0, A=B=0, ex_regwen=0.
- **Plain capture:** ADD with rdat1=5, rdat2=7 → next cycle A=5, B=7, ALUOP=ALU_ADD; I-type with alusrc=1, imm=0xFFFFFFFC → B=0xFFFFFFFC.
- **Forward priority:** EX rs=3; exmem_wsel=3 with 0x11 and memwb_wsel=3 with 0x22 → A=0x11. Drop exmem_regwen → A=0x22. Use rs=0 with both matching → A = latched value.
- **Hold retention:** hold=1 while memwb forwards 0x55 to rt for one cycle, then memwb changes → B stays 0x55.
- **Load-use:** EX is LW to $8; decode uses rs=$8 → load_use=1; next cycle ex_valid=0 and load_use=0; the cycle after, the dependent instruction is captured. With hold=1 instead, load_use stays 0.
- **Flush:** flush=1 with dec_valid=1 → ex_valid=0 next cycle; flush and hold together → squashed.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types for the ID/EX operand stage and its forwarding muxes.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  localparam regbits_t REG_ZERO = 5'd0;

  typedef struct packed {
    logic     valid;
    regbits_t rs;
    regbits_t rt;
    logic     uses_rs;
    logic     uses_rt;
    word_t    opa;
    word_t    opb;
    word_t    imm;
    regbits_t shamt;
    logic     alusrc;
    aluop_t   aluop;
    regbits_t wsel;
    logic     regwen;
    logic     memren;
  } idex_t;

  // Immediate shifts take their A operand from shamt rather than rs.
  function automatic logic is_shift(input aluop_t op);
    logic res;
    case (op)
      ALU_SLL: res = 1'b1;
      ALU_SRL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/idex_operand_stage_fwd_mux.sv
// Resolves one source operand against the EX/MEM and MEM/WB write ports.
module fwd_mux
  import cpu_types_pkg::*;
(
  input  logic [4:0]  src,
  input  logic [31:0] latched,
  input  logic [4:0]  exmem_wsel,
  input  logic        exmem_regwen,
  input  logic [31:0] exmem_result,
  input  logic [4:0]  memwb_wsel,
  input  logic        memwb_regwen,
  input  logic [31:0] memwb_result,
  output logic [31:0] resolved
);

  // The younger EX/MEM result shadows MEM/WB; $0 is never forwarded.
  always_comb begin
    resolved = latched;
    if (exmem_regwen && (exmem_wsel == src) && (src != REG_ZERO)) begin
      resolved = exmem_result;
    end else if (memwb_regwen && (memwb_wsel == src) && (src != REG_ZERO)) begin
      resolved = memwb_result;
    end else begin
      resolved = latched;
    end
  end

endmodule

// File: rtl/idex_operand_stage.sv
// ID/EX pipeline latch: forwards operands into the ALU ports and flags load-use hazards.
module idex_operand_stage
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        dec_valid,
  input  logic [4:0]  dec_rs,
  input  logic [4:0]  dec_rt,
  input  logic        dec_uses_rs,
  input  logic        dec_uses_rt,
  input  logic [31:0] dec_rdat1,
  input  logic [31:0] dec_rdat2,
  input  logic [31:0] dec_imm,
  input  logic [4:0]  dec_shamt,
  input  logic        dec_alusrc,
  input  aluop_t      dec_aluop,
  input  logic [4:0]  dec_wsel,
  input  logic        dec_regwen,
  input  logic        dec_memren,
  input  logic [4:0]  exmem_wsel,
  input  logic        exmem_regwen,
  input  logic [31:0] exmem_result,
  input  logic [4:0]  memwb_wsel,
  input  logic        memwb_regwen,
  input  logic [31:0] memwb_result,
  input  logic        hold,
  input  logic        flush,
  output logic        load_use,
  output logic        ex_valid,
  output logic [31:0] A,
  output logic [31:0] B,
  output aluop_t      ALUOP,
  output logic [4:0]  ex_wsel,
  output logic        ex_regwen,
  output logic        ex_memren,
  output logic [31:0] ex_rtdata
);

  idex_t       ex_r;
  idex_t       dec_s;
  logic [31:0] rs_val_s;
  logic [31:0] rt_val_s;

  fwd_mux u_fwd_rs (
    .src          (ex_r.rs),
    .latched      (ex_r.opa),
    .exmem_wsel   (exmem_wsel),
    .exmem_regwen (exmem_regwen),
    .exmem_result (exmem_result),
    .memwb_wsel   (memwb_wsel),
    .memwb_regwen (memwb_regwen),
    .memwb_result (memwb_result),
    .resolved     (rs_val_s)
  );

  fwd_mux u_fwd_rt (
    .src          (ex_r.rt),
    .latched      (ex_r.opb),
    .exmem_wsel   (exmem_wsel),
    .exmem_regwen (exmem_regwen),
    .exmem_result (exmem_result),
    .memwb_wsel   (memwb_wsel),
    .memwb_regwen (memwb_regwen),
    .memwb_result (memwb_result),
    .resolved     (rt_val_s)
  );

  // Pack the decode bundle into the latch layout.
  always_comb begin
    dec_s         = '0;
    dec_s.valid   = dec_valid;
    dec_s.rs      = dec_rs;
    dec_s.rt      = dec_rt;
    dec_s.uses_rs = dec_uses_rs;
    dec_s.uses_rt = dec_uses_rt;
    dec_s.opa     = dec_rdat1;
    dec_s.opb     = dec_rdat2;
    dec_s.imm     = dec_imm;
    dec_s.shamt   = dec_shamt;
    dec_s.alusrc  = dec_alusrc;
    dec_s.aluop   = dec_aluop;
    dec_s.wsel    = dec_wsel;
    dec_s.regwen  = dec_regwen;
    dec_s.memren  = dec_memren;
  end

  // A live load in EX whose target is read by decode; suppressed while stalled or squashed.
  always_comb begin
    load_use = 1'b0;
    if (hold || flush) begin
      load_use = 1'b0;
    end else if (ex_r.valid && ex_r.memren && (ex_r.wsel != REG_ZERO)) begin
      load_use = (dec_uses_rs && (dec_rs == ex_r.wsel)) ||
                 (dec_uses_rt && (dec_rt == ex_r.wsel));
    end else begin
      load_use = 1'b0;
    end
  end

  // Latch update; a hold writes forwarded values back so they outlive MEM/WB retirement.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_r <= '0;
    end else if (flush) begin
      ex_r.valid <= 1'b0;
    end else if (hold) begin
      ex_r.opa <= rs_val_s;
      ex_r.opb <= rt_val_s;
    end else if (load_use) begin
      ex_r.valid  <= 1'b0;
      ex_r.regwen <= 1'b0;
      ex_r.memren <= 1'b0;
    end else begin
      ex_r <= dec_s;
    end
  end

  // ALU operand selection.
  always_comb begin
    A = rs_val_s;
    B = rt_val_s;
    if (is_shift(ex_r.aluop)) begin
      A = {27'd0, ex_r.shamt};
      B = rt_val_s;
    end else if (ex_r.alusrc) begin
      A = rs_val_s;
      B = ex_r.imm;
    end else begin
      A = rs_val_s;
      B = rt_val_s;
    end
  end

  assign ALUOP     = ex_r.aluop;
  assign ex_valid  = ex_r.valid;
  assign ex_wsel   = ex_r.wsel;
  assign ex_regwen = ex_r.valid & ex_r.regwen;
  assign ex_memren = ex_r.valid & ex_r.memren;
  assign ex_rtdata = rt_val_s;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Directed plus randomized bench for idex_operand_stage against a behavioural model.
module tb_idex_operand_stage;
  import cpu_types_pkg::*;

  logic        CLK, RST;
  logic        dec_valid, dec_uses_rs, dec_uses_rt, dec_alusrc, dec_regwen, dec_memren;
  logic [4:0]  dec_rs, dec_rt, dec_shamt, dec_wsel;
  logic [31:0] dec_rdat1, dec_rdat2, dec_imm;
  aluop_t      dec_aluop;
  logic [4:0]  exmem_wsel, memwb_wsel;
  logic        exmem_regwen, memwb_regwen;
  logic [31:0] exmem_result, memwb_result;
  logic        hold, flush;
  logic        load_use, ex_valid, ex_regwen, ex_memren;
  logic [31:0] A, B, ex_rtdata;
  aluop_t      ALUOP;
  logic [4:0]  ex_wsel;

  int n_checks = 0;
  int n_errors = 0;

  idex_operand_stage dut (
    .CLK(CLK), .RST(RST),
    .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
    .dec_rdat1(dec_rdat1), .dec_rdat2(dec_rdat2), .dec_imm(dec_imm),
    .dec_shamt(dec_shamt), .dec_alusrc(dec_alusrc), .dec_aluop(dec_aluop),
    .dec_wsel(dec_wsel), .dec_regwen(dec_regwen), .dec_memren(dec_memren),
    .exmem_wsel(exmem_wsel), .exmem_regwen(exmem_regwen), .exmem_result(exmem_result),
    .memwb_wsel(memwb_wsel), .memwb_regwen(memwb_regwen), .memwb_result(memwb_result),
    .hold(hold), .flush(flush), .load_use(load_use), .ex_valid(ex_valid),
    .A(A), .B(B), .ALUOP(ALUOP), .ex_wsel(ex_wsel), .ex_regwen(ex_regwen),
    .ex_memren(ex_memren), .ex_rtdata(ex_rtdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model of the instruction sitting in EX.
  logic        m_valid, m_urs, m_urt, m_alusrc, m_regwen, m_memren;
  logic [4:0]  m_rs, m_rt, m_shamt, m_wsel;
  logic [31:0] m_opa, m_opb, m_imm;
  logic [3:0]  m_aluop;

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
    if (r == 5'd0) return d;
    if (exmem_regwen && exmem_wsel == r) return exmem_result;
    if (memwb_regwen && memwb_wsel == r) return memwb_result;
    return d;
  endfunction

  function automatic logic exp_lu();
    if (hold || flush || !m_valid || !m_memren || m_wsel == 5'd0) return 1'b0;
    return (dec_uses_rs && dec_rs == m_wsel) || (dec_uses_rt && dec_rt == m_wsel);
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_valid <= 1'b0; m_urs <= 1'b0; m_urt <= 1'b0; m_alusrc <= 1'b0;
      m_regwen <= 1'b0; m_memren <= 1'b0; m_rs <= 5'd0; m_rt <= 5'd0;
      m_shamt <= 5'd0; m_wsel <= 5'd0; m_opa <= 32'd0; m_opb <= 32'd0;
      m_imm <= 32'd0; m_aluop <= 4'd0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (hold) begin
      m_opa <= fwd(m_rs, m_opa);
      m_opb <= fwd(m_rt, m_opb);
    end else if (exp_lu()) begin
      m_valid <= 1'b0; m_regwen <= 1'b0; m_memren <= 1'b0;
    end else begin
      m_valid <= dec_valid; m_urs <= dec_uses_rs; m_urt <= dec_uses_rt;
      m_alusrc <= dec_alusrc; m_regwen <= dec_regwen; m_memren <= dec_memren;
      m_rs <= dec_rs; m_rt <= dec_rt; m_shamt <= dec_shamt; m_wsel <= dec_wsel;
      m_opa <= dec_rdat1; m_opb <= dec_rdat2; m_imm <= dec_imm; m_aluop <= 4'(dec_aluop);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [31:0] rsv, rtv, ea, eb;
    logic        shift;
    rsv   = fwd(m_rs, m_opa);
    rtv   = fwd(m_rt, m_opb);
    shift = (m_aluop == 4'd0) || (m_aluop == 4'd1);
    ea    = shift ? {27'd0, m_shamt} : rsv;
    eb    = (shift || !m_alusrc) ? rtv : m_imm;
    check_val("ex_valid", 32'(ex_valid), 32'(m_valid));
    check_val("load_use", 32'(load_use), 32'(exp_lu()));
    check_val("ex_regwen", 32'(ex_regwen), 32'(m_valid & m_regwen));
    check_val("ex_memren", 32'(ex_memren), 32'(m_valid & m_memren));
    if (m_valid) begin
      check_val("A", A, ea);
      check_val("B", B, eb);
      check_val("ALUOP", 32'(ALUOP), 32'(m_aluop));
      check_val("ex_wsel", 32'(ex_wsel), 32'(m_wsel));
      check_val("ex_rtdata", ex_rtdata, rtv);
    end
  endtask

  task automatic idle();
    RST = 1'b0; dec_valid = 1'b0; dec_rs = 5'd0; dec_rt = 5'd0;
    dec_uses_rs = 1'b0; dec_uses_rt = 1'b0; dec_rdat1 = 32'd0; dec_rdat2 = 32'd0;
    dec_imm = 32'd0; dec_shamt = 5'd0; dec_alusrc = 1'b0; dec_aluop = ALU_ADD;
    dec_wsel = 5'd0; dec_regwen = 1'b0; dec_memren = 1'b0;
    exmem_wsel = 5'd0; exmem_regwen = 1'b0; exmem_result = 32'd0;
    memwb_wsel = 5'd0; memwb_regwen = 1'b0; memwb_result = 32'd0;
    hold = 1'b0; flush = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    idle();
    RST = 1'b1; dec_valid = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    check_val("rst_valid", 32'(ex_valid), 32'd0);
    check_val("rst_A", A, 32'd0);
    check_val("rst_B", B, 32'd0);
    check_val("rst_regwen", 32'(ex_regwen), 32'd0);
    check_val("rst_load_use", 32'(load_use), 32'd0);

    // Plain R-type and I-type capture
    idle(); dec_valid = 1'b1; dec_rs = 5'd1; dec_rt = 5'd2; dec_uses_rs = 1'b1;
    dec_uses_rt = 1'b1; dec_rdat1 = 32'd5; dec_rdat2 = 32'd7; dec_wsel = 5'd4; dec_regwen = 1'b1;
    next_cycle(); idle(); #1;
    check_val("add_A", A, 32'd5);
    check_val("add_B", B, 32'd7);
    check_val("add_op", 32'(ALUOP), 32'(ALU_ADD));
    check_val("add_regwen", 32'(ex_regwen), 32'd1);
    dec_valid = 1'b1; dec_rs = 5'd1; dec_uses_rs = 1'b1; dec_rdat1 = 32'd3;
    dec_imm = 32'hFFFF_FFFC; dec_alusrc = 1'b1;
    next_cycle(); idle(); #1;
    check_val("imm_B", B, 32'hFFFF_FFFC);

    // Forwarding priority and $0 exclusion
    dec_valid = 1'b1; dec_rs = 5'd3; dec_uses_rs = 1'b1; dec_rdat1 = 32'h99;
    next_cycle(); idle();
    exmem_wsel = 5'd3; exmem_regwen = 1'b1; exmem_result = 32'h11;
    memwb_wsel = 5'd3; memwb_regwen = 1'b1; memwb_result = 32'h22;
    #1 check_val("fwd_exmem", A, 32'h11);
    exmem_regwen = 1'b0;
    #1 check_val("fwd_memwb", A, 32'h22);
    idle(); dec_valid = 1'b1; dec_rs = 5'd0; dec_uses_rs = 1'b1; dec_rdat1 = 32'h77;
    next_cycle(); idle();
    exmem_wsel = 5'd0; exmem_regwen = 1'b1; exmem_result = 32'h11;
    memwb_wsel = 5'd0; memwb_regwen = 1'b1; memwb_result = 32'h22;
    #1 check_val("fwd_r0", A, 32'h77);

    // Hold retains forwarded data after MEM/WB moves on
    idle(); dec_valid = 1'b1; dec_rt = 5'd5; dec_uses_rt = 1'b1; dec_rdat2 = 32'h10;
    next_cycle(); idle(); hold = 1'b1;
    memwb_wsel = 5'd5; memwb_regwen = 1'b1; memwb_result = 32'h55;
    #1 check_val("hold_fwd_B", B, 32'h55);
    next_cycle(); idle(); hold = 1'b1;
    memwb_wsel = 5'd6; memwb_regwen = 1'b1; memwb_result = 32'h66;
    #1 check_val("hold_keep_B", B, 32'h55);

    // Load-use: one bubble, then the dependent instruction enters EX
    idle(); dec_valid = 1'b1; dec_rs = 5'd1; dec_memren = 1'b1; dec_regwen = 1'b1; dec_wsel = 5'd8;
    next_cycle(); idle();
    dec_valid = 1'b1; dec_rs = 5'd8; dec_uses_rs = 1'b1; dec_rdat1 = 32'h100;
    dec_aluop = ALU_SUB; dec_wsel = 5'd9; dec_regwen = 1'b1;
    #1 check_val("lu_assert", 32'(load_use), 32'd1);
    next_cycle(); #1;
    check_val("lu_bubble", 32'(ex_valid), 32'd0);
    check_val("lu_clear", 32'(load_use), 32'd0);
    next_cycle(); idle(); #1;
    check_val("lu_dep_valid", 32'(ex_valid), 32'd1);
    check_val("lu_dep_wsel", 32'(ex_wsel), 32'd9);
    check_val("lu_dep_op", 32'(ALUOP), 32'(ALU_SUB));
    dec_valid = 1'b1; dec_rs = 5'd1; dec_memren = 1'b1; dec_regwen = 1'b1; dec_wsel = 5'd8;
    next_cycle(); idle();
    dec_valid = 1'b1; dec_rs = 5'd8; dec_uses_rs = 1'b1; hold = 1'b1;
    #1 check_val("lu_hold_gated", 32'(load_use), 32'd0);

    // Flush, alone and together with hold
    next_cycle(); idle(); dec_valid = 1'b1; dec_regwen = 1'b1; dec_wsel = 5'd3; flush = 1'b1;
    next_cycle(); idle(); #1;
    check_val("flush_valid", 32'(ex_valid), 32'd0);
    check_val("flush_regwen", 32'(ex_regwen), 32'd0);
    dec_valid = 1'b1; dec_regwen = 1'b1; dec_wsel = 5'd3;
    next_cycle(); idle(); flush = 1'b1; hold = 1'b1;
    #1 check_val("fh_pre_valid", 32'(ex_valid), 32'd1);
    next_cycle(); idle(); #1;
    check_val("fh_squash", 32'(ex_valid), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      RST          = ($urandom_range(0, 39) == 0);
      flush        = ($urandom_range(0, 7) == 0);
      hold         = ($urandom_range(0, 3) == 0);
      dec_valid    = ($urandom_range(0, 3) != 0);
      dec_rs       = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      dec_rt       = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      dec_uses_rs  = 1'($urandom);
      dec_uses_rt  = 1'($urandom);
      dec_rdat1    = $urandom;
      dec_rdat2    = $urandom;
      dec_imm      = $urandom;
      dec_shamt    = 5'($urandom);
      dec_alusrc   = 1'($urandom);
      dec_aluop    = aluop_t'(4'($urandom_range(0, 9)));
      dec_wsel     = 5'($urandom_range(0, 3));
      dec_regwen   = 1'($urandom);
      dec_memren   = ($urandom_range(0, 2) == 0);
      exmem_wsel   = 5'($urandom_range(0, 3));
      exmem_regwen = 1'($urandom);
      exmem_result = $urandom;
      memwb_wsel   = 5'($urandom_range(0, 3));
      memwb_regwen = 1'($urandom);
      memwb_result = $urandom;
      #1 compare_all();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
